ellipse_renderer_multi: RTL

Parametrised successor to the single-ellipse renderer. Holds NUM_ELLIPSES independently programmable ellipse slots and overlays them onto a streamed pixel, lowest slot index on top. Sits in the pixel stream between the pixel source and the framebuffer writer. Fixed-latency pipeline with valid qualification.

---
 rtl/ellipse_pkg.sv | 43 ++++
 rtl/ellipse_hit_test.sv | 81 ++++++++
 rtl/ellipse_renderer_multi.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/ellipse_pkg.sv
// Shared definitions for the multi-slot ellipse renderer.
//
// Contents: per-slot register addresses, pipeline latency (depends on the
// ELLIPSE_ALPHA_BLEND_EN macro), ARGB8888 field offsets, the slot style
// register struct and the per-channel alpha blend helper.
package ellipse_pkg;

    localparam int unsigned REG_CX     = 0;
    localparam int unsigned REG_CY     = 1;
    localparam int unsigned REG_A      = 2;
    localparam int unsigned REG_B      = 3;
    localparam int unsigned REG_COLOR  = 4;
    localparam int unsigned REG_ENABLE = 5;

`ifdef ELLIPSE_ALPHA_BLEND_EN
    localparam int unsigned LAT = 5;
`else
    localparam int unsigned LAT = 4;
`endif

    localparam int unsigned ARGB_W     = 32;
    localparam int unsigned ARGB_A_LSB = 24;
    localparam int unsigned ARGB_R_LSB = 16;
    localparam int unsigned ARGB_G_LSB = 8;
    localparam int unsigned ARGB_B_LSB = 0;

    // Colour and enable of one slot. Geometry widths are parameters of the
    // top, so CX/CY/A/B are held there in per-field arrays.
    typedef struct packed {
        logic              enable;
        logic [ARGB_W-1:0] color;
    } slot_regs_t;

    // (fg*a + bg*(255-a) + 127) / 255, with the divide approximated as
    // (v + 1 + (v >> 8)) >> 8.
    function automatic logic [7:0] blend_chan(input logic [7:0] fg, input logic [7:0] bg,
                                              input logic [7:0] alpha);
        logic [16:0] v;
        v = 17'(fg) * 17'(alpha) + 17'(bg) * 17'(8'd255 - alpha) + 17'd127;
        return 8'((v + 17'd1 + (v >> 8)) >> 8);
    endfunction

endpackage

// File: rtl/ellipse_hit_test.sv
// Per-slot ellipse membership test, three register stages.
//
// Ports:
//   clk_i              clock
//   x_i, y_i           pixel coordinate (registered in S1)
//   cx_i, cy_i         ellipse centre (sampled in S1 with the pixel)
//   a_i, b_i           semi-axes (sampled in S1)
//   enable_i           slot enable (sampled in S1)
//   hit_o              inside/on-boundary flag, valid in S3
// Pure datapath without reset: pixel validity is tracked by the top.
module ellipse_hit_test #(
    parameter int unsigned X_W = 11,
    parameter int unsigned Y_W = 12
) (
    input  logic           clk_i,
    input  logic [X_W-1:0] x_i,
    input  logic [Y_W-1:0] y_i,
    input  logic [X_W-1:0] cx_i,
    input  logic [Y_W-1:0] cy_i,
    input  logic [X_W-1:0] a_i,
    input  logic [Y_W-1:0] b_i,
    input  logic           enable_i,
    output logic           hit_o
);

    localparam int unsigned DX2_W = 2 * X_W + 2;
    localparam int unsigned DY2_W = 2 * Y_W + 2;
    localparam int unsigned A2_W  = 2 * X_W;
    localparam int unsigned B2_W  = 2 * Y_W;
    localparam int unsigned PW    = 2 * X_W + 2 * Y_W + 3;

    logic [X_W:0]       dx_d;
    logic [Y_W:0]       dy_d;

    logic [X_W:0]       dx1_q;
    logic [Y_W:0]       dy1_q;
    logic [X_W-1:0]     a1_q;
    logic [Y_W-1:0]     b1_q;
    logic               ok1_q;

    logic [DX2_W-1:0]   dx2_q;
    logic [DY2_W-1:0]   dy2_q;
    logic [A2_W-1:0]    a2_q;
    logic [B2_W-1:0]    b2_q;
    logic               ok2_q;

    logic [PW-1:0]      lhs_d;
    logic [PW-1:0]      rhs_d;
    logic               hit_q;

    always_comb begin
        dx_d = (x_i >= cx_i) ? {1'b0, x_i - cx_i} : {1'b0, cx_i - x_i};
        dy_d = (y_i >= cy_i) ? {1'b0, y_i - cy_i} : {1'b0, cy_i - y_i};
    end

    // Boundary counts as inside, hence <=.
    always_comb begin
        lhs_d = PW'(dx2_q) * PW'(b2_q) + PW'(dy2_q) * PW'(a2_q);
        rhs_d = PW'(a2_q) * PW'(b2_q);
    end

    always_ff @(posedge clk_i) begin
        // S1
        dx1_q <= dx_d;
        dy1_q <= dy_d;
        a1_q  <= a_i;
        b1_q  <= b_i;
        ok1_q <= enable_i && (a_i != '0) && (b_i != '0);
        // S2
        dx2_q <= DX2_W'(dx1_q) * DX2_W'(dx1_q);
        dy2_q <= DY2_W'(dy1_q) * DY2_W'(dy1_q);
        a2_q  <= A2_W'(a1_q) * A2_W'(a1_q);
        b2_q  <= B2_W'(b1_q) * B2_W'(b1_q);
        ok2_q <= ok1_q;
        // S3
        hit_q <= ok2_q && (lhs_d <= rhs_d);
    end

    assign hit_o = hit_q;

endmodule

// File: rtl/ellipse_renderer_multi.sv
// Overlays NUM_ELLIPSES programmable ellipses onto a streamed pixel.
// Lowest slot index is on top. Fixed latency LAT, one pixel per cycle.
//
// Ports:
//   clk, rst (sync, active high)
//   program_in  1: register write (x = slot, y = address, data_in = value)
//   valid_in    pixel qualifier when program_in = 0
//   x, y        pixel coordinate
//   data_in     background colour (ARGB8888)
//   valid_out, x_out, y_out, data_out  composited pixel; held when not valid
// Optional: ELLIPSE_ALPHA_BLEND_EN adds a blend stage (LAT 5 instead of 4).
module ellipse_renderer_multi
    import ellipse_pkg::*;
#(
    parameter int unsigned X_W          = 11,
    parameter int unsigned Y_W          = 12,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned NUM_ELLIPSES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              program_in,
    input  logic              valid_in,
    input  logic [X_W-1:0]    x,
    input  logic [Y_W-1:0]    y,
    input  logic [DATA_W-1:0] data_in,
    output logic              valid_out,
    output logic [X_W-1:0]    x_out,
    output logic [Y_W-1:0]    y_out,
    output logic [DATA_W-1:0] data_out
);

    logic accept;
    assign accept = !program_in && valid_in;

    // Register file
    logic [X_W-1:0] cx_q   [NUM_ELLIPSES];
    logic [Y_W-1:0] cy_q   [NUM_ELLIPSES];
    logic [X_W-1:0] a_q    [NUM_ELLIPSES];
    logic [Y_W-1:0] b_q    [NUM_ELLIPSES];
    slot_regs_t     slot_q [NUM_ELLIPSES];

    // Out-of-range slot indices match no loop iteration and are dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(NUM_ELLIPSES); i++) begin
                cx_q[i]   <= '0;
                cy_q[i]   <= '0;
                a_q[i]    <= '0;
                b_q[i]    <= '0;
                slot_q[i] <= '0;
            end
        end else if (program_in) begin
            for (int i = 0; i < int'(NUM_ELLIPSES); i++) begin
                if (32'(x) == i) begin
                    case (32'(y))
                        REG_CX:     cx_q[i]          <= data_in[X_W-1:0];
                        REG_CY:     cy_q[i]          <= data_in[Y_W-1:0];
                        REG_A:      a_q[i]           <= data_in[X_W-1:0];
                        REG_B:      b_q[i]           <= data_in[Y_W-1:0];
                        REG_COLOR:  slot_q[i].color  <= data_in;
                        REG_ENABLE: slot_q[i].enable <= data_in[0];
                        default:    ;
                    endcase
                end
            end
        end
    end

    // Pixel sideband pipeline S1..S3; slot colours travel with the pixel so
    // a mid-stream COLOR write does not touch pixels already in flight.
    logic [2:0]        pv_q;
    logic [X_W-1:0]    px_q   [3];
    logic [Y_W-1:0]    py_q   [3];
    logic [DATA_W-1:0] pbg_q  [3];
    logic [DATA_W-1:0] pcol_q [3][NUM_ELLIPSES];

    always_ff @(posedge clk) begin
        if (rst) pv_q <= '0;
        else     pv_q <= {pv_q[1:0], accept};
    end

    always_ff @(posedge clk) begin
        px_q[0]  <= x;
        py_q[0]  <= y;
        pbg_q[0] <= data_in;
        for (int i = 0; i < int'(NUM_ELLIPSES); i++) pcol_q[0][i] <= slot_q[i].color;
        for (int s = 1; s < 3; s++) begin
            px_q[s]   <= px_q[s-1];
            py_q[s]   <= py_q[s-1];
            pbg_q[s]  <= pbg_q[s-1];
            pcol_q[s] <= pcol_q[s-1];
        end
    end

    logic [NUM_ELLIPSES-1:0] hit3;

    for (genvar i = 0; i < int'(NUM_ELLIPSES); i++) begin : g_slot
        ellipse_hit_test #(
            .X_W (X_W),
            .Y_W (Y_W)
        ) u_hit (
            .clk_i    (clk),
            .x_i      (x),
            .y_i      (y),
            .cx_i     (cx_q[i]),
            .cy_i     (cy_q[i]),
            .a_i      (a_q[i]),
            .b_i      (b_q[i]),
            .enable_i (slot_q[i].enable),
            .hit_o    (hit3[i])
        );
    end

    // Priority select: scanning downward lets the lowest hit index win.
    logic [DATA_W-1:0] sel_col;
    always_comb begin
        sel_col = pbg_q[2];
        for (int i = int'(NUM_ELLIPSES) - 1; i >= 0; i--) begin
            if (hit3[i]) sel_col = pcol_q[2][i];
        end
    end

    logic              ov_d;
    logic [X_W-1:0]    ox_d;
    logic [Y_W-1:0]    oy_d;
    logic [DATA_W-1:0] od_d;

`ifdef ELLIPSE_ALPHA_BLEND_EN
    logic              v4_q;
    logic              hit4_q;
    logic [X_W-1:0]    x4_q;
    logic [Y_W-1:0]    y4_q;
    logic [DATA_W-1:0] col4_q;
    logic [DATA_W-1:0] bg4_q;
    logic [DATA_W-1:0] blend_d;

    always_ff @(posedge clk) begin
        if (rst) v4_q <= 1'b0;
        else     v4_q <= pv_q[2];
    end

    always_ff @(posedge clk) begin
        hit4_q <= |hit3;
        x4_q   <= px_q[2];
        y4_q   <= py_q[2];
        col4_q <= sel_col;
        bg4_q  <= pbg_q[2];
    end

    always_comb begin
        blend_d = bg4_q;
        if (hit4_q) begin
            blend_d[ARGB_A_LSB +: 8] = 8'hff;
            blend_d[ARGB_R_LSB +: 8] = blend_chan(col4_q[ARGB_R_LSB +: 8],
                                                  bg4_q[ARGB_R_LSB +: 8],
                                                  col4_q[ARGB_A_LSB +: 8]);
            blend_d[ARGB_G_LSB +: 8] = blend_chan(col4_q[ARGB_G_LSB +: 8],
                                                  bg4_q[ARGB_G_LSB +: 8],
                                                  col4_q[ARGB_A_LSB +: 8]);
            blend_d[ARGB_B_LSB +: 8] = blend_chan(col4_q[ARGB_B_LSB +: 8],
                                                  bg4_q[ARGB_B_LSB +: 8],
                                                  col4_q[ARGB_A_LSB +: 8]);
        end
    end

    always_comb begin
        ov_d = v4_q;
        ox_d = x4_q;
        oy_d = y4_q;
        od_d = blend_d;
    end
`else
    always_comb begin
        ov_d = pv_q[2];
        ox_d = px_q[2];
        oy_d = py_q[2];
        od_d = sel_col;
    end
`endif

    // Output register; payload holds while no valid pixel arrives.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_out <= 1'b0;
            x_out     <= '0;
            y_out     <= '0;
            data_out  <= '0;
        end else begin
            valid_out <= ov_d;
            if (ov_d) begin
                x_out    <= ox_d;
                y_out    <= oy_d;
                data_out <= od_d;
            end
        end
    end

endmodule
